// File: rtl/gilbert_error_injector.sv
// Gilbert-Elliott error injector: corrupts each accepted word one bit per cycle,
// flipping bits with a probability chosen by the current channel state.
module gilbert_error_injector #(
  parameter int unsigned DATA_W = 8,
  parameter logic [8:0]  P_GOOD = 9'd0,
  parameter logic [8:0]  P_BAD  = 9'd256,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              channel_state,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_err_mask,
  input  logic              clear_stats,
  output logic [31:0]       err_count,
  output logic [31:0]       bit_count,
  output logic [31:0]       bad_bit_count,
  output logic [1:0]        dbg_state
);

  // Handshakes: a word moves on an edge where valid && ready. in_ready and
  // out_valid are decoded from the registered state only, so neither depends
  // combinationally on the opposite side's valid/ready.

  localparam int unsigned IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PROC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [DATA_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [DATA_W-1:0] omask_q, omask_d;
  logic [31:0]       err_q, err_d;
  logic [31:0]       bits_q, bits_d;
  logic [31:0]       bad_q, bad_d;

  logic [7:0] rand8;
  logic [8:0] thr;
  logic       flip;
  logic       lfsr_fb;
  logic       last_bit;
  logic       proc_active;

  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic inc);
    return (inc && (c != 32'hFFFF_FFFF)) ? c + 32'd1 : c;
  endfunction

  assign rand8       = lfsr_q[7:0];
  assign thr         = channel_state ? P_GOOD : P_BAD;
  assign flip        = ({1'b0, rand8} < thr);
  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Fibonacci form.
  assign lfsr_fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign last_bit    = (idx_q == IDX_W'(DATA_W - 1));
  assign proc_active = (state_q == S_PROC);

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    idx_d     = idx_q;
    work_d    = work_q;
    wmask_d   = wmask_q;
    odata_d   = odata_q;
    omask_d   = omask_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_data;
          wmask_d = '0;
          idx_d   = '0;
          state_d = S_PROC;
        end
      end
      S_PROC: begin
        lfsr_d         = {lfsr_fb, lfsr_q[15:1]};
        work_d[idx_q]  = work_q[idx_q] ^ flip;
        wmask_d[idx_q] = flip;
        if (last_bit) begin
          // Output registers only load on a finished word, so nothing partial leaks.
          odata_d = work_d;
          omask_d = wmask_d;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    err_d  = err_q;
    bits_d = bits_q;
    bad_d  = bad_q;
    if (clear_stats) begin
      err_d  = '0;
      bits_d = '0;
      bad_d  = '0;
    end else if (proc_active) begin
      err_d  = sat_inc(err_q, flip);
      bits_d = sat_inc(bits_q, 1'b1);
      bad_d  = sat_inc(bad_q, ~channel_state);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      idx_q   <= '0;
      work_q  <= '0;
      wmask_q <= '0;
      odata_q <= '0;
      omask_q <= '0;
      err_q   <= '0;
      bits_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      wmask_q <= wmask_d;
      odata_q <= odata_d;
      omask_q <= omask_d;
      err_q   <= err_d;
      bits_q  <= bits_d;
      bad_q   <= bad_d;
    end
  end

  assign out_data      = odata_q;
  assign out_err_mask  = omask_q;
  assign err_count     = err_q;
  assign bit_count     = bits_q;
  assign bad_bit_count = bad_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_gilbert_error_injector.sv
// Bench for gilbert_error_injector: two instances with different thresholds share
// the stimulus; a queue-based scoreboard checks both against a behavioural model.
module tb_gilbert_error_injector;

  localparam int W = 8;
  localparam logic [8:0]  PG_A = 9'd0;
  localparam logic [8:0]  PB_A = 9'd256;
  localparam logic [8:0]  PG_B = 9'd26;
  localparam logic [8:0]  PB_B = 9'd200;
  localparam logic [15:0] SEED_A = 16'h1234;
  localparam logic [15:0] SEED_B = 16'h0000;

  logic clk, reset, channel_state, in_valid, out_ready, clear_stats;
  logic [W-1:0] in_data;
  logic in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [W-1:0] out_data_a, out_err_mask_a, out_data_b, out_err_mask_b;
  logic [31:0] err_count_a, bit_count_a, bad_bit_count_a;
  logic [31:0] err_count_b, bit_count_b, bad_bit_count_b;
  logic [1:0] dbg_state_a, dbg_state_b;

  gilbert_error_injector #(.DATA_W(W), .P_GOOD(PG_A), .P_BAD(PB_A), .SEED(SEED_A)) dut_a (
    .clk(clk), .reset(reset), .channel_state(channel_state),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_err_mask(out_err_mask_a), .clear_stats(clear_stats),
    .err_count(err_count_a), .bit_count(bit_count_a), .bad_bit_count(bad_bit_count_a),
    .dbg_state(dbg_state_a)
  );

  gilbert_error_injector #(.DATA_W(W), .P_GOOD(PG_B), .P_BAD(PB_B), .SEED(SEED_B)) dut_b (
    .clk(clk), .reset(reset), .channel_state(channel_state),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_err_mask(out_err_mask_b), .clear_stats(clear_stats),
    .err_count(err_count_b), .bit_count(bit_count_b), .bad_bit_count(bad_bit_count_b),
    .dbg_state(dbg_state_b)
  );

  typedef struct {
    logic [W-1:0] data_a, mask_a, data_b, mask_b;
    logic [31:0]  bits, bad, err_a, err_b;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_err = 0;
  int n_pushed = 0;
  int n_out = 0;
  logic force_low = 1'b1;
  logic held = 1'b0;
  logic [W-1:0] held_data, held_mask;

  // Behavioural model state
  logic [15:0] m_lfsr_a, m_lfsr_b;
  logic [31:0] m_bits, m_bad, m_err_a, m_err_b;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    n_cmp++; n_err++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int unsigned v, b;
    v = s;
    b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] c, input int unsigned inc);
    longint unsigned t;
    t = longint'(c) + inc;
    return (t > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
  endfunction

  task automatic model_reset();
    m_lfsr_a = (SEED_A == 0) ? 16'hACE1 : SEED_A;
    m_lfsr_b = (SEED_B == 0) ? 16'hACE1 : SEED_B;
    m_bits = 0; m_bad = 0; m_err_a = 0; m_err_b = 0;
  endtask

  // Runs one word through the model: random byte from the low LFSR bits,
  // flip when it is below the threshold for that bit's channel state.
  task automatic model_word(input logic [W-1:0] data, input logic [W-1:0] pat,
                            input int clear_at, output exp_t e);
    int ra, rb, ta, tb;
    logic fa, fb;
    e.mask_a = '0; e.mask_b = '0;
    for (int i = 0; i < W; i++) begin
      ra = m_lfsr_a & 255;
      rb = m_lfsr_b & 255;
      ta = pat[i] ? int'(PG_A) : int'(PB_A);
      tb = pat[i] ? int'(PG_B) : int'(PB_B);
      fa = (ra < ta);
      fb = (rb < tb);
      e.mask_a[i] = fa;
      e.mask_b[i] = fb;
      if (i == clear_at) begin
        m_bits = 0; m_bad = 0; m_err_a = 0; m_err_b = 0;
      end else begin
        m_bits  = sat_add(m_bits, 1);
        m_bad   = sat_add(m_bad, pat[i] ? 0 : 1);
        m_err_a = sat_add(m_err_a, fa ? 1 : 0);
        m_err_b = sat_add(m_err_b, fb ? 1 : 0);
      end
      m_lfsr_a = lfsr_step(m_lfsr_a);
      m_lfsr_b = lfsr_step(m_lfsr_b);
    end
    e.data_a = data ^ e.mask_a;
    e.data_b = data ^ e.mask_b;
    e.bits = m_bits; e.bad = m_bad; e.err_a = m_err_a; e.err_b = m_err_b;
  endtask

  // ---------------- drivers ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_in_ready();
    int budget = 0;
    while (!in_ready_a && budget < 200) begin
      @(posedge clk); #1; budget++;
    end
    check("in_ready_timeout", {31'd0, in_ready_a}, 32'd1);
  endtask

  task automatic send_word(input logic [W-1:0] data, input logic [W-1:0] pat, input int clear_at);
    exp_t e;
    model_word(data, pat, clear_at, e);
    exp_q.push_back(e);
    n_pushed++;
    in_valid = 1'b1; in_data = data; channel_state = pat[0];
    wait_in_ready();
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = W'($urandom);
    for (int i = 0; i < W; i++) begin
      channel_state = pat[i];
      clear_stats = (i == clear_at);
      @(posedge clk); #1;
      clear_stats = 1'b0;
      if (i < W - 1) begin
        check("busy_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("busy_in_ready", {31'd0, in_ready_a}, 32'd0);
      end
    end
    check("latency_out_valid", {31'd0, out_valid_a}, 32'd1);
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(posedge clk); #1; budget++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic clear_pulse();
    clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    m_bits = 0; m_bad = 0; m_err_a = 0; m_err_b = 0;
    check("clear_bits", bit_count_a, 32'd0);
    check("clear_err", err_count_a, 32'd0);
    check("clear_bad", bad_bit_count_b, 32'd0);
  endtask

  task automatic check_counters_model(input string tag);
    check({tag, "_bits"}, bit_count_a, m_bits);
    check({tag, "_bad"}, bad_bit_count_a, m_bad);
    check({tag, "_err_a"}, err_count_a, m_err_a);
    check({tag, "_err_b"}, err_count_b, m_err_b);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      held <= 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", {31'd0, out_valid_a}, 32'd1);
        check("hold_data", out_data_a, held_data);
        check("hold_mask", out_err_mask_a, held_mask);
      end
      if (out_valid_a) begin
        check("valid_b", {31'd0, out_valid_b}, 32'd1);
        if (out_ready) begin
          held <= 1'b0;
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_output: got data %0h, expected no word", out_data_a);
          end else begin
            mon_e = exp_q.pop_front();
            n_out++;
            check("data_a", out_data_a, mon_e.data_a);
            check("mask_a", out_err_mask_a, mon_e.mask_a);
            check("data_b", out_data_b, mon_e.data_b);
            check("mask_b", out_err_mask_b, mon_e.mask_b);
            check("mask_rel_b", out_data_b ^ out_err_mask_b, out_data_a ^ out_err_mask_a);
            check("bit_count", bit_count_a, mon_e.bits);
            check("bad_bit_count", bad_bit_count_b, mon_e.bad);
            check("err_count_a", err_count_a, mon_e.err_a);
            check("err_count_b", err_count_b, mon_e.err_b);
          end
        end else begin
          held <= 1'b1;
          held_data <= out_data_a;
          held_mask <= out_err_mask_a;
        end
      end else begin
        held <= 1'b0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    real r;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; channel_state = 1'b1; clear_stats = 1'b0;
    model_reset();
    #1;
    check("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("rst_out_data", out_data_a, 32'd0);
    check("rst_mask", out_err_mask_b, 32'd0);
    check_counters_model("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    force_low = 1'b0;

    // Good channel, no flips on A
    send_word(8'hA5, 8'hFF, -1);
    drain();
    // Bad channel, all flips on A
    clear_pulse();
    send_word(8'hA5, 8'h00, -1);
    drain();
    // Alternating channel starting bad: A flips even bits
    clear_pulse();
    send_word(8'h00, 8'hAA, -1);
    drain();

    // Back-pressure in DONE with a pending word upstream
    force_low = 1'b1;
    send_word(8'h96, W'($urandom), -1);
    in_valid = 1'b1; in_data = 8'h3C;
    for (int k = 0; k < 5; k++) begin
      check("stall_in_ready", {31'd0, in_ready_a}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid_a}, 32'd1);
      check_counters_model("stall");
      @(posedge clk); #1;
    end
    force_low = 1'b0;
    send_word(8'h3C, W'($urandom), -1);
    drain();

    // Reset in the middle of processing
    in_valid = 1'b1; in_data = W'($urandom); channel_state = 1'b0;
    wait_in_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    model_reset();
    check("midrst_in_ready", {31'd0, in_ready_a}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid_a | out_valid_b}, 32'd0);
    check("midrst_out_data", out_data_a, 32'd0);
    check_counters_model("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    // clear_stats during a processing cycle; LFSR restart checked through masks
    send_word(W'($urandom), W'($urandom), 4);
    drain();

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      send_word(W'($urandom), W'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, W - 1)) : -1);
    end
    drain();

    // Long good-channel run for the error-rate estimate on B
    clear_pulse();
    for (int n = 0; n < 2000; n++) begin
      send_word(8'h00, 8'hFF, -1);
    end
    drain();
    check("stats_bits", bit_count_b, 32'd16000);
    r = (bit_count_b == 0) ? 0.0 : real'(err_count_b) / real'(bit_count_b);
    n_cmp++;
    if (r < (26.0 / 256.0) - 0.01 || r > (26.0 / 256.0) + 0.01) begin
      n_err++;
      $display("FAIL stats_ratio: got %f, expected %f +/- 0.01", r, 26.0 / 256.0);
    end

    check("queue_empty", exp_q.size(), 32'd0);
    check("outputs_seen", n_out, n_pushed);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
